// File: rtl/diff_scan_ctrl_pkg.sv
// Shared state encodings, default geometry and clog2 for the diff scan sequencer.
package diff_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DIFF_WIDTH = 32;
  localparam int DIFF_CHUNK = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/diff_scan_ctrl_chunk_lsb_enc.sv
// Combinational lowest-set-bit encoder for one CHUNK-bit slice of the xor word.
module chunk_lsb_enc
  import diff_scan_ctrl_pkg::*;
#(
  parameter int CHUNK = DIFF_CHUNK,
  parameter int LW    = (CHUNK > 1) ? clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] vec_i,
  output logic             any_o,
  output logic [LW-1:0]    idx_o
);

  // Walk MSB to LSB so the last hit left standing is the lowest set bit.
  always_comb begin
    any_o = |vec_i;
    idx_o = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = LW'(i);
    end
  end

endmodule

// File: rtl/diff_scan_ctrl.sv
// Multi-cycle lowest-differing-bit search: latches a^b, scans CHUNK bits per cycle LSB first.
// Optional DIFF_ZERO_SKIP_EN: equal operands resolve after a single SCAN cycle.
module diff_scan_ctrl
  import diff_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = DIFF_WIDTH,
  parameter int CHUNK = DIFF_CHUNK,
  parameter int IDXW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      diff,
  output logic             found,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? clog2(NCH) : 1;
  localparam int LW  = (CHUNK > 1) ? clog2(CHUNK) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [KW-1:0]     k_q, k_d;
  logic [IDXW-1:0]   diff_q, diff_d;
  logic              found_q, found_d;
  logic              ov_q, ov_d;

  logic [CHUNK-1:0]  chunk;
  logic              any;
  logic [LW-1:0]     lsb;

  assign chunk = x_q[int'(k_q)*CHUNK +: CHUNK];

  chunk_lsb_enc #(.CHUNK(CHUNK), .LW(LW)) u_enc (
    .vec_i (chunk),
    .any_o (any),
    .idx_o (lsb)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    k_d     = k_q;
    diff_d  = diff_q;
    found_d = found_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = a ^ b;
          k_d     = '0;
          state_d = ST_SCAN;
`ifdef DIFF_ZERO_SKIP_EN
          // Jump straight to the last chunk so the all-zero exit fires on the first SCAN edge.
          if (~|(a ^ b)) k_d = KW'(NCH - 1);
`endif
        end
      end
      ST_SCAN: begin
        if (any) begin
          diff_d  = IDXW'(k_q) * IDXW'(CHUNK) + IDXW'(lsb);
          found_d = 1'b1;
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end else if (k_q == KW'(NCH - 1)) begin
          diff_d  = IDXW'(WIDTH);
          found_d = 1'b0;
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over everything; the last published result stays on diff/found.
    if (abort) begin
      state_d = ST_IDLE;
      ov_d    = 1'b0;
      x_d     = x_q;
      k_d     = k_q;
      diff_d  = diff_q;
      found_d = found_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      k_q     <= '0;
      diff_q  <= '0;
      found_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      k_q     <= k_d;
      diff_q  <= diff_d;
      found_q <= found_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign out_valid = ov_q;
  assign found     = found_q;
  assign diff      = {{(32-IDXW){1'b0}}, diff_q};

endmodule

// File: tb/tb_diff_scan_ctrl.sv
// Directed bench for diff_scan_ctrl at WIDTH=32, CHUNK=4.
module tb_diff_scan_ctrl;

  logic        clk, rst, abort, in_valid, in_ready, out_valid, out_ready, found, busy;
  logic [31:0] a, b, diff;
  int checks = 0;
  int errors = 0;

`ifdef DIFF_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 8;
`endif

  diff_scan_ctrl dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .found(found), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input int ed,
                        input logic ef, input int el, input string tag);
    int n;
    a = ta; b = tb_; in_valid = 1'b1;
    chk({tag, ".rdy"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    a = ~ta; b = 32'h1234_5678;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 20);
    chk({tag, ".lat"}, n, el);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".found"}, found, ef);
    chk({tag, ".rdy_done"}, in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".ov_clr"}, out_valid, 0);
    chk({tag, ".rdy_idle"}, in_ready, 1);
  endtask

  function automatic int ref_idx(input logic [31:0] x);
    int idx;
    idx = 32;
    for (int i = 31; i >= 0; i--) if (x[i]) idx = i;
    return idx;
  endfunction

  initial begin
    logic seen;
    logic [31:0] ra, rb;
    int ri;
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.diff", diff, 0);
    chk("rst.found", found, 0);
    @(negedge clk); rst = 1'b1;
    step();

    // single-bit sweep
    for (int i = 0; i < 32; i++)
      run_op(32'h0, 32'h1 << i, i, 1'b1, i / 4 + 1, $sformatf("sweep%0d", i));

    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32, 1'b0, ZLAT, "equal");

    // backpressure with in_valid held during SCAN/DONE
    a = 32'h0000_0100; b = 32'h0; in_valid = 1'b1;
    step();
    a = 32'h1; b = 32'h0;
    step(); step();
    chk("bp.ov_e2", out_valid, 0);
    step();
    chk("bp.ov_e3", out_valid, 1);
    chk("bp.diff_e3", diff, 8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.hold_diff", diff, 8);
      chk("bp.hold_rdy", in_ready, 0);
      chk("bp.hold_ov", out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp.hs_ov", out_valid, 0);
    chk("bp.hs_rdy", in_ready, 1);
    step();
    chk("bp.acc_rdy", in_ready, 0);
    in_valid = 1'b0;
    step();
    chk("bp.op2_ov", out_valid, 1);
    chk("bp.op2_diff", diff, 0);
    chk("bp.op2_found", found, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // abort mid-SCAN
    a = 32'h0; b = 32'h0001_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort.rdy_e2", in_ready, 1);
    chk("abort.ov_e2", out_valid, 0);
    chk("abort.busy_e2", busy, 0);
    step();
    chk("abort.rdy_e3", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= out_valid;
    end
    chk("abort.never_ov", seen, 0);
    chk("abort.diff_kept", diff, 0);
    chk("abort.found_kept", found, 1);

    // abort in DONE
    a = 32'h2; b = 32'h0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("abort_done.ov", out_valid, 1);
    chk("abort_done.diff", diff, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done.ov_clr", out_valid, 0);
    chk("abort_done.rdy", in_ready, 1);
    chk("abort_done.diff_kept", diff, 1);
    chk("abort_done.found_kept", found, 1);

    // abort beats accept in IDLE
    abort = 1'b1; in_valid = 1'b1; a = 32'h4; b = 32'h0;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle.rdy", in_ready, 1);
    chk("abort_idle.busy", busy, 0);
    step();
    chk("abort_idle.busy2", busy, 0);

    // async reset mid-SCAN at E3
    a = 32'h0; b = 32'h8000_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk("rst_scan.rdy", in_ready, 1);
    chk("rst_scan.busy", busy, 0);
    chk("rst_scan.ov", out_valid, 0);
    chk("rst_scan.diff", diff, 0);
    chk("rst_scan.found", found, 0);
    @(negedge clk); rst = 1'b1;
    step();
    run_op(32'h0, 32'h8000_0000, 31, 1'b1, 8, "post_rst");

    // back-to-back ops
    run_op(32'h0000_0F00, 32'h0, 8, 1'b1, 3, "b2b1");
    run_op(32'h0000_0030, 32'h0000_0010, 5, 1'b1, 2, "b2b2");
    run_op(32'h0000_0001, 32'h0000_0003, 1, 1'b1, 1, "b2b3");

    // random pairs against a reference model
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = (i % 10 == 0) ? ra : ($urandom >> $urandom_range(0, 31));
      rb = (i % 10 == 0) ? rb : (rb ^ (ra & ~(32'hFFFF_FFFF >> $urandom_range(0, 31))));
      ri = ref_idx(ra ^ rb);
      run_op(ra, rb, ri, (ri != 32), (ri == 32) ? ZLAT : ri / 4 + 1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
